// File: rtl/agc_gain_apply.sv
// AGC gain application stage: scales the I/Q sample stream by a mantissa/exponent
// gain word, with round-half-up, saturation, sample-aligned gain switching and an overload count.
module agc_gain_apply #(
   parameter int IN_W       = 12,
   parameter int OUT_W      = 12,
   parameter int EXP_OFFSET = 10,
   parameter int SAT_CNT_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [IN_W-1:0]      sample_i,
   input  logic signed [IN_W-1:0]      sample_q,
   input  logic        [7:0]           mantissa,
   input  logic        [3:0]           exp,
   input  logic                        gain_load,
   output logic                        gain_ack,
   output logic                        out_valid,
   output logic signed [OUT_W-1:0]     out_i,
   output logic signed [OUT_W-1:0]     out_q,
   output logic                        sat_flag,
   output logic        [SAT_CNT_W-1:0] sat_count,
   input  logic                        sat_count_clr
);

   localparam int PW = IN_W + 10;
   // Room for the rounding constant (up to 2^22) on top of the product.
   localparam int EW = ((PW > 22) ? PW : 22) + 2;
   localparam logic [5:0]           R_BASE = 6'(8 + EXP_OFFSET);
   localparam logic signed [EW-1:0] Y_MAX  = EW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [EW-1:0] Y_MIN  = ~Y_MAX;
   localparam logic signed [EW-1:0] ONE    = {{(EW-1){1'b0}}, 1'b1};

   // Result bit OUT_W flags a clip; lower bits are the rounded, saturated value.
   function automatic logic [OUT_W:0] round_sat(input logic signed [PW-1:0] p,
                                                input logic        [5:0]    r);
      logic signed [EW-1:0] ext;
      logic signed [EW-1:0] rnd;
      logic signed [EW-1:0] y;
      logic        [OUT_W:0] res;
      ext = {{(EW-PW){p[PW-1]}}, p};
      if (r != 6'd0) begin
         rnd = ONE <<< (r - 6'd1);
      end else begin
         rnd = {EW{1'b0}};
      end
      y = (ext + rnd) >>> r;
      if (y > Y_MAX) begin
         res = {1'b1, Y_MAX[OUT_W-1:0]};
      end else if (y < Y_MIN) begin
         res = {1'b1, Y_MIN[OUT_W-1:0]};
      end else begin
         res = {1'b0, y[OUT_W-1:0]};
      end
      return res;
   endfunction

   logic [7:0] act_man_q, act_man_d, pend_man_q, pend_man_d;
   logic [3:0] act_exp_q, act_exp_d, pend_exp_q, pend_exp_d;
   logic       pend_flag_q, pend_flag_d;
   logic       gain_ack_q;
   logic       transfer_s;
   logic [7:0] use_man_s;
   logic [3:0] use_exp_s;

   logic                   s1_v_q;
   logic signed [IN_W-1:0] s1_i_q, s1_q_q;
   logic        [7:0]      s1_man_q;
   logic        [3:0]      s1_exp_q;
   logic signed [9:0]      gain_s;
   logic signed [PW-1:0]   prod_i_s, prod_q_s;

   logic                   s2_v_q;
   logic signed [PW-1:0]   s2_p_i_q, s2_p_q_q;
   logic        [3:0]      s2_exp_q;
   logic        [5:0]      shift_s;
   logic        [OUT_W:0]  res_i_s, res_q_s;

   logic                   out_valid_q, sat_flag_q, sat_flag_d;
   logic        [OUT_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
   logic   [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

   // The pending gain moves to active on the first sample after it was loaded.
   assign transfer_s = in_valid & pend_flag_q;
   assign use_man_s  = transfer_s ? pend_man_q : act_man_q;
   assign use_exp_s  = transfer_s ? pend_exp_q : act_exp_q;

   // Next-state of the active/pending gain registers.
   always_comb begin
      act_man_d   = act_man_q;
      act_exp_d   = act_exp_q;
      pend_man_d  = pend_man_q;
      pend_exp_d  = pend_exp_q;
      pend_flag_d = pend_flag_q;
      if (transfer_s) begin
         act_man_d   = pend_man_q;
         act_exp_d   = pend_exp_q;
         pend_flag_d = 1'b0;
      end else begin
         act_man_d   = act_man_q;
         act_exp_d   = act_exp_q;
      end
      if (gain_load) begin
         pend_man_d  = mantissa;
         pend_exp_d  = exp;
         pend_flag_d = 1'b1;
      end else begin
         pend_man_d  = pend_man_q;
         pend_exp_d  = pend_exp_q;
      end
   end

   // {01, mantissa} is the unsigned 256+mantissa as a positive signed operand.
   assign gain_s   = $signed({2'b01, s1_man_q});
   assign prod_i_s = PW'(s1_i_q) * PW'(gain_s);
   assign prod_q_s = PW'(s1_q_q) * PW'(gain_s);

   assign shift_s  = R_BASE - {2'b00, s2_exp_q};
   assign res_i_s  = round_sat(s2_p_i_q, shift_s);
   assign res_q_s  = round_sat(s2_p_q_q, shift_s);

   // Output stage next-state: hold data between strobes, saturating counter with clear priority.
   always_comb begin
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      sat_flag_d  = 1'b0;
      sat_count_d = sat_count_q;
      if (s2_v_q) begin
         out_i_d    = res_i_s[OUT_W-1:0];
         out_q_d    = res_q_s[OUT_W-1:0];
         sat_flag_d = res_i_s[OUT_W] | res_q_s[OUT_W];
      end else begin
         out_i_d    = out_i_q;
         out_q_d    = out_q_q;
      end
      if (sat_count_clr) begin
         sat_count_d = {SAT_CNT_W{1'b0}};
      end else if (out_valid_q && sat_flag_q && !(&sat_count_q)) begin
         sat_count_d = sat_count_q + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         sat_count_d = sat_count_q;
      end
   end

   // All state: gain registers, three pipeline stages, outputs and counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_man_q   <= 8'd0;
         act_exp_q   <= 4'(EXP_OFFSET);
         pend_man_q  <= 8'd0;
         pend_exp_q  <= 4'd0;
         pend_flag_q <= 1'b0;
         gain_ack_q  <= 1'b0;
         s1_v_q      <= 1'b0;
         s1_i_q      <= {IN_W{1'b0}};
         s1_q_q      <= {IN_W{1'b0}};
         s1_man_q    <= 8'd0;
         s1_exp_q    <= 4'd0;
         s2_v_q      <= 1'b0;
         s2_p_i_q    <= {PW{1'b0}};
         s2_p_q_q    <= {PW{1'b0}};
         s2_exp_q    <= 4'd0;
         out_valid_q <= 1'b0;
         out_i_q     <= {OUT_W{1'b0}};
         out_q_q     <= {OUT_W{1'b0}};
         sat_flag_q  <= 1'b0;
         sat_count_q <= {SAT_CNT_W{1'b0}};
      end else begin
         act_man_q   <= act_man_d;
         act_exp_q   <= act_exp_d;
         pend_man_q  <= pend_man_d;
         pend_exp_q  <= pend_exp_d;
         pend_flag_q <= pend_flag_d;
         gain_ack_q  <= transfer_s;
         s1_v_q      <= in_valid;
         s1_i_q      <= sample_i;
         s1_q_q      <= sample_q;
         s1_man_q    <= use_man_s;
         s1_exp_q    <= use_exp_s;
         s2_v_q      <= s1_v_q;
         s2_p_i_q    <= prod_i_s;
         s2_p_q_q    <= prod_q_s;
         s2_exp_q    <= s1_exp_q;
         out_valid_q <= s2_v_q;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         sat_flag_q  <= sat_flag_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign gain_ack  = gain_ack_q;
   assign out_valid = out_valid_q;
   assign out_i     = out_i_q;
   assign out_q     = out_q_q;
   assign sat_flag  = sat_flag_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_agc_gain_apply.sv
// Scoreboard bench for agc_gain_apply: the stimulus side predicts each output from an
// arithmetic gain model; a negedge monitor compares outputs, gain_ack and sat_count.
module tb_agc_gain_apply;
   localparam int IN_W       = 12;
   localparam int OUT_W      = 12;
   localparam int EXP_OFFSET = 10;
   localparam int SCW        = 4;
   localparam int CNT_MAX    = (1 << SCW) - 1;

   logic                 clk, rst, in_valid, gain_load, sat_count_clr;
   logic [IN_W-1:0]      sample_i, sample_q;
   logic [7:0]           mantissa;
   logic [3:0]           g_exp;
   logic                 gain_ack, out_valid, sat_flag;
   logic [OUT_W-1:0]     out_i, out_q;
   logic [SCW-1:0]       sat_count;

   agc_gain_apply #(.IN_W(IN_W), .OUT_W(OUT_W), .EXP_OFFSET(EXP_OFFSET), .SAT_CNT_W(SCW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sample_i(sample_i), .sample_q(sample_q),
      .mantissa(mantissa), .exp(g_exp), .gain_load(gain_load), .gain_ack(gain_ack),
      .out_valid(out_valid), .out_i(out_i), .out_q(out_q), .sat_flag(sat_flag),
      .sat_count(sat_count), .sat_count_clr(sat_count_clr));

   typedef struct {
      logic [OUT_W-1:0] i;
      logic [OUT_W-1:0] q;
      bit               sat;
      int               due;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   act_m, act_e, pend_m, pend_e;
   bit   pend_f;
   bit   ack_sched = 1'b0;
   bit   ack_exp   = 1'b0;
   int   cnt_model = 0;
   logic [OUT_W-1:0] last_i = '0;
   logic [OUT_W-1:0] last_q = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ack_exp <= rst ? ack_sched : 1'b0;
   end

   function automatic longint floor_div(longint a, longint b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // Nearest integer to s * (256+m)/256 * 2^(e-EXP_OFFSET), ties toward +inf.
   function automatic longint ref_y(int s, int m, int e);
      longint num, den;
      num = longint'(s) * longint'(256 + m);
      den = longint'(1) <<< (8 + EXP_OFFSET - e);
      return floor_div(2 * num + den, 2 * den);
   endfunction

   function automatic longint clamp(longint y, output bit sat);
      longint hi, lo;
      hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
      lo  = -(longint'(1) <<< (OUT_W - 1));
      sat = (y > hi) || (y < lo);
      if (y > hi) return hi;
      if (y < lo) return lo;
      return y;
   endfunction

   task automatic check(string name, longint got, longint want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step(bit v, int si, int sq, bit ld, int m, int e, bit clr);
      bit     transfer, si_sat, sq_sat;
      int     um, ue;
      longint yi, yq;
      exp_t   x;
      @(posedge clk);
      #1;
      in_valid      = v;
      sample_i      = si[IN_W-1:0];
      sample_q      = sq[IN_W-1:0];
      gain_load     = ld;
      mantissa      = m[7:0];
      g_exp         = e[3:0];
      sat_count_clr = clr;
      transfer = v && pend_f;
      um = transfer ? pend_m : act_m;
      ue = transfer ? pend_e : act_e;
      if (v) begin
         yi    = clamp(ref_y(si, um, ue), si_sat);
         yq    = clamp(ref_y(sq, um, ue), sq_sat);
         x.i   = yi[OUT_W-1:0];
         x.q   = yq[OUT_W-1:0];
         x.sat = si_sat || sq_sat;
         x.due = cyc + 3;
         sb.push_back(x);
      end
      if (transfer) begin
         act_m  = pend_m;
         act_e  = pend_e;
         pend_f = 1'b0;
      end
      if (ld) begin
         pend_m = m;
         pend_e = e;
         pend_f = 1'b1;
      end
      ack_sched = transfer;
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   // One-cycle reset; with_sample also offers a sample in the reset cycle, which must be dropped.
   task automatic do_reset(bit with_sample);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      in_valid      = with_sample;
      sample_i      = 12'd700;
      sample_q      = 12'd700;
      gain_load     = 1'b0;
      sat_count_clr = 1'b0;
      act_m = 0; act_e = EXP_OFFSET; pend_f = 1'b0; ack_sched = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
   endtask

   // Monitor: compare every strobe against the scoreboard and track sat_count.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         sb.delete();
         cnt_model = 0;
         last_i    = '0;
         last_q    = '0;
         check("rst_out_valid", out_valid, 0);
         check("rst_sat_count", sat_count, 0);
         check("rst_gain_ack", gain_ack, 0);
      end else begin
         check("gain_ack", gain_ack, ack_exp);
         check("sat_count", sat_count, cnt_model);
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_i", $signed(out_i), $signed(e.i));
               check("out_q", $signed(out_q), $signed(e.q));
               check("sat_flag", sat_flag, e.sat);
               check("latency_cycle", cyc, e.due);
               last_i = e.i;
               last_q = e.q;
               if (sat_count_clr) cnt_model = 0;
               else if (e.sat && cnt_model < CNT_MAX) cnt_model++;
            end
         end else begin
            check("hold_out_i", $signed(out_i), $signed(last_i));
            check("hold_out_q", $signed(out_q), $signed(last_q));
            if (sat_count_clr) cnt_model = 0;
         end
         if (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing_out_valid", 0, 1);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; gain_load = 1'b0; sat_count_clr = 1'b0;
      sample_i = '0; sample_q = '0; mantissa = '0; g_exp = '0;
      act_m = 0; act_e = EXP_OFFSET; pend_m = 0; pend_e = 0; pend_f = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Unity gain out of reset.
      step(1'b1, 1000, -1000, 1'b0, 0, 0, 1'b0);
      idle(4);
      // Gain 1.5.
      step(1'b0, 0, 0, 1'b1, 128, 10, 1'b0);
      step(1'b1, 1000, -1000, 1'b0, 0, 0, 1'b0);
      idle(4);
      // Gain 0.5 rounding cases.
      step(1'b0, 0, 0, 1'b1, 0, 9, 1'b0);
      step(1'b1, 3, -3, 1'b0, 0, 0, 1'b0);
      step(1'b1, 2047, -2048, 1'b0, 0, 0, 1'b0);
      idle(4);
      // Saturation and counter, then clear coincident with a saturating strobe.
      step(1'b0, 0, 0, 1'b1, 255, 15, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, 100, -100, 1'b0, 0, 0, 1'b0);
      idle(4);
      step(1'b1, 100, -100, 1'b0, 0, 0, 1'b0);
      idle(2);
      step(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
      idle(3);
      // Gain boundary on a back-to-back stream.
      do_reset(1'b0);
      step(1'b1, 400, 400, 1'b1, 0, 11, 1'b0);
      step(1'b1, 400, 400, 1'b0, 0, 0, 1'b0);
      step(1'b1, 400, 400, 1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 0, 12, 1'b0);
      step(1'b0, 0, 0, 1'b1, 0, 9, 1'b0);
      step(1'b1, 400, 400, 1'b0, 0, 0, 1'b0);
      step(1'b1, 400, 400, 1'b1, 77, 13, 1'b0);
      step(1'b1, 400, 400, 1'b1, 5, 8, 1'b0);
      step(1'b1, 400, 400, 1'b0, 0, 0, 1'b0);
      idle(4);
      // Randomized traffic, drives the counter into its sticky top value.
      for (int k = 0; k < 700; k++) begin
         step(($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048, ($urandom_range(0, 9) == 0),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 99) == 0));
      end
      // Reset with samples in flight, then unity gain again.
      step(1'b0, 0, 0, 1'b1, 255, 15, 1'b0);
      step(1'b1, 100, -100, 1'b0, 0, 0, 1'b0);
      step(1'b1, 100, -100, 1'b0, 0, 0, 1'b0);
      do_reset(1'b1);
      idle(4);
      step(1'b1, 1000, -1000, 1'b0, 0, 0, 1'b0);
      idle(6);
      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
